// File: rtl/data_memory_responder_pkg.sv
// Shared constants and types for the data-side memory responder.
// Size encodings, FSM states, core opcodes and an alignment helper.
package data_memory_responder_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_RSVD = 2'b11;

   typedef enum logic [6:0] {
      OPCODE_LOAD  = 7'b0000011,
      OPCODE_STORE = 7'b0100011
   } opcode_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic        err;
      logic [1:0]  size;
      logic [1:0]  lane;
      logic [31:0] wdata;
   } req_t;

   function automatic logic misaligned(input logic [1:0] size,
                                       input logic [1:0] lane);
      logic bad;
      bad = 1'b1;
      unique case (size)
         SIZE_BYTE: bad = 1'b0;
         SIZE_HALF: bad = lane[0];
         SIZE_WORD: bad = |lane;
         SIZE_RSVD: bad = 1'b1;
         default:   bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between a 32-bit RAM word and right-aligned data.
// Shared by the data- and instruction-side responders.
module dmem_lane_align
   import data_memory_responder_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic [31:0] store_data,
   input  logic [31:0] load_word,
   output logic [3:0]  byte_mask,
   output logic [31:0] store_word,
   output logic [31:0] load_data
);

   always_comb begin
      byte_mask  = 4'b0000;
      store_word = 32'h0;
      load_data  = 32'h0;
      unique case (size)
         SIZE_BYTE: begin
            byte_mask  = 4'b0001 << lane;
            store_word = {4{store_data[7:0]}};
            load_data  = {24'h0, load_word[{lane, 3'b000} +: 8]};
         end
         SIZE_HALF: begin
            byte_mask  = lane[1] ? 4'b1100 : 4'b0011;
            store_word = {2{store_data[15:0]}};
            load_data  = {16'h0, lane[1] ? load_word[31:16]
                                         : load_word[15:0]};
         end
         SIZE_WORD: begin
            byte_mask  = 4'b1111;
            store_word = store_data;
            load_data  = load_word;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/data_memory_responder.sv
// Data-bus responder: word RAM with wait states, ready pulse and faults.
// Define DMEM_PERF_COUNTERS_EN to add read/write/error counters.
module data_memory_responder
   import data_memory_responder_pkg::*;
#(
   parameter int                    DEPTH_WORDS  = 1024,
   parameter int                    ADDR_WIDTH   = 32,
   parameter int                    WAIT_STATES  = 1,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = 32'h00000000
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  data_memory_read,
   input  logic                  data_memory_write,
   input  logic [1:0]            data_option,
   input  logic [ADDR_WIDTH-1:0] data_address,
   input  logic [31:0]           write_data,
   output logic [31:0]           read_data,
   output logic                  data_ready,
   output logic                  data_error,
   output logic                  busy
`ifdef DMEM_PERF_COUNTERS_EN
   ,
   output logic [31:0]           read_count,
   output logic [31:0]           write_count,
   output logic [15:0]           error_count
`endif
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_LAST =
      (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   state_t state, state_next;
   logic [3:0] cnt, cnt_next;
   logic capture;
   logic fault;
   logic [ADDR_WIDTH-1:0] offset;

   req_t op;
   logic [IDX_W-1:0] op_idx;

   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] cur_word;
   logic [3:0]  byte_mask;
   logic [31:0] store_word;
   logic [31:0] load_data;
   logic        mem_we;

   assign offset = data_address - BASE_ADDRESS;
   assign busy   = (state != S_IDLE);

   always_comb begin
      fault = misaligned(data_option, offset[1:0]);
      if ((offset >> (IDX_W + 2)) != '0)
         fault = 1'b1;
      if (data_memory_read && data_memory_write)
         fault = 1'b1;
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      capture    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (data_memory_read || data_memory_write) begin
               capture    = 1'b1;
               cnt_next   = 4'd0;
               state_next = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
            end
         end
         S_WAIT: begin
            if (cnt == WAIT_LAST) begin
               cnt_next   = 4'd0;
               state_next = S_RESP;
            end else begin
               cnt_next = cnt + 4'd1;
            end
         end
         S_RESP:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op     <= '0;
         op_idx <= '0;
      end else if (capture) begin
         op.rd    <= data_memory_read;
         op.wr    <= data_memory_write;
         op.err   <= fault;
         op.size  <= data_option;
         op.lane  <= offset[1:0];
         op.wdata <= write_data;
         op_idx   <= offset[IDX_W+1:2];
      end
   end

   assign cur_word = mem[op_idx];

   dmem_lane_align u_align (
      .size       (op.size),
      .lane       (op.lane),
      .store_data (op.wdata),
      .load_word  (cur_word),
      .byte_mask  (byte_mask),
      .store_word (store_word),
      .load_data  (load_data)
   );

   // Reset drops the FSM out of RESP, so an aborted write never commits.
   assign mem_we = (state == S_RESP) && op.wr && !op.err;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_mask[b])
               mem[op_idx][b*8 +: 8] <= store_word[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         read_data  <= 32'h0;
         data_ready <= 1'b0;
         data_error <= 1'b0;
      end else begin
         data_ready <= (state == S_RESP);
         data_error <= (state == S_RESP) && op.err;
         if (state == S_RESP && op.rd)
            read_data <= op.err ? 32'h0 : load_data;
      end
   end

`ifdef DMEM_PERF_COUNTERS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         read_count  <= 32'h0;
         write_count <= 32'h0;
         error_count <= 16'h0;
      end else if (state == S_RESP) begin
         if (op.err) begin
            if (error_count != 16'hFFFF)
               error_count <= error_count + 16'h1;
         end else begin
            if (op.rd)
               read_count <= read_count + 32'h1;
            if (op.wr)
               write_count <= write_count + 32'h1;
         end
      end
   end
`endif

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder end of the core's data bus: accepts read/write requests (read strobe, write strobe, size option, byte address, write data) and returns read data.
- Owns a word-organised, byte-addressable RAM array.
- Adds programmable wait states, a one-cycle ready pulse, and misalignment/size error reporting.
- Sits between the core's data port and the SoC top; a later bus arbiter connects here.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two.
- ADDR_WIDTH, 32, width of data_address.
- WAIT_STATES, 1, extra cycles between request capture and response; 0..15.
- BASE_ADDRESS, 32'h00000000, byte address mapped to word 0.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- data_memory_read  in  1  read request strobe.
- data_memory_write  in  1  write request strobe.
- data_option  in  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
- data_address  in  ADDR_WIDTH  byte address.
- write_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- read_data  out  32  load data, right-aligned and zero-extended.
- data_ready  out  1  one-cycle pulse: response valid / write committed.
- data_error  out  1  one-cycle pulse, coincident with data_ready, for a faulted request.
- busy  out  1  high from request capture through the response cycle.

Behaviour:
- Reset (reset = 0, asynchronous) forces:
  - FSM to IDLE and the wait counter to 0.
  - read_data = 0, data_ready = 0, data_error = 0, busy = 0.
  - RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On a rising edge with read or write = 1: capture the operation, option, offset (address - BASE_ADDRESS), and write_data.
  - Then go to WAIT if WAIT_STATES > 0, else RESP. Set busy = 1.
- WAIT: the counter counts up to WAIT_STATES - 1, then the FSM goes to RESP.
- RESP:
  - data_ready = 1 for exactly one cycle.
  - A read drives read_data; a write updates the RAM at this edge.
  - Next state is always IDLE and busy falls. A new request can be captured on the first IDLE edge, so back-to-back throughput is WAIT_STATES + 2 cycles.
- Latency: data_ready is asserted WAIT_STATES + 1 cycles after the capture edge.
- Requests arriving while busy = 1 are ignored; the initiator must hold or re-issue them.
- Read and write both high at capture: no RAM change, read_data = 0, data_error = 1.
- Error conditions: option 11, misaligned address (half with offset[0] = 1, word with offset[1:0] != 0), or word index >= DEPTH_WORDS.
  - A faulted read returns 0; a faulted write leaves the RAM unchanged.
  - data_ready still pulses.
- Lane rules: word index = offset[log2(DEPTH_WORDS)+1:2]; lane = offset[1:0].
  - Byte read returns mem[lane*8 +: 8] zero-extended.
  - Half read uses lane 0 or 2.
  - Writes modify only the addressed byte lanes.
- read_data holds its last value after the response until the next read response or reset.
- Reset asserted mid-WAIT aborts the access: a pending write is never committed and no data_ready is produced.

Optional Feature:
- Macro: DMEM_PERF_COUNTERS_EN.
- Defined:
  - Adds outputs read_count[31:0], write_count[31:0], and error_count[15:0].
  - Each counter increments in RESP for the matching access; error_count saturates at 16'hFFFF, the others wrap.
  - All three clear on reset.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package constants:
  - Size encodings: SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b10.
  - FSM state encoding.
  - LOAD/STORE opcode values already used by the core.
- Sub-module dmem_lane_align (combinational): from option and lane, produces the byte-write mask and shifted write word, and right-aligns read data. It is reused later for the instruction-side responder.

Test Plan:
- WAIT_STATES = 1: write word 0xDEADBEEF to 0x10, then read word 0x10 -> data_ready 2 cycles after each capture; read_data = 0xDEADBEEF; data_error = 0.
- Byte write 0xAA to 0x13 over word 0x11223344, then read word 0x10 -> 0xAA223344. Half read at 0x12 -> 0x0000AA22.
- Word read at 0x12 -> data_error = 1 with data_ready; read_data = 0; RAM unchanged. Option 11 read at 0x0 -> same.
- Second request raised while busy, then dropped before IDLE -> ignored; exactly one data_ready. WAIT_STATES = 0 -> data_ready on the cycle after capture.
- Reset pulled low during WAIT of a write to 0x20 -> the later read of 0x20 returns the old value; outputs are 0 during reset.
- With DMEM_PERF_COUNTERS_EN: 3 reads, 2 writes, 1 misaligned read -> read_count = 3, write_count = 2, error_count = 1 (faulted accesses are counted only in error_count).
